// File: rtl/regfile_dump.sv
// Sequential register-file reader: walks an inclusive address range and streams each value out on valid/ready.
// Optional feature macro REGDUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned N_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [WIDTH-1:0]  r_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [WIDTH-1:0]  dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_last,
  output logic              dout_csum,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(N_REGS - 1);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd4
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [WIDTH-1:0]    dout_data_q, dout_data_d;
  logic [ADDR_W-1:0]   dout_idx_q, dout_idx_d;
  logic                dout_valid_q, dout_valid_d;
  logic                dout_last_q, dout_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   last_clamp;
  logic                handshake;
`ifdef REGDUMP_CHECKSUM_EN
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                dout_csum_q, dout_csum_d;
`endif

  // Addresses beyond the file are pinned to the top register
  assign last_clamp = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;
  assign handshake  = dout_valid_q && dout_ready;

  always_comb begin
    state_d      = state_q;
    r_addr_d     = r_addr_q;
    last_d       = last_q;
    dout_data_d  = dout_data_q;
    dout_idx_d   = dout_idx_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    acc_d        = acc_q;
    dout_csum_d  = dout_csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          acc_d  = '0;
`endif
          if (first_addr <= last_clamp) begin
            last_d   = last_clamp;
            r_addr_d = first_addr;
            state_d  = S_FETCH;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
      S_FETCH: begin
        dout_data_d  = r_data;
        dout_idx_d   = r_addr_q;
        dout_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        // The checksum beat carries the end-of-dump marker instead
        dout_last_d  = 1'b0;
        dout_csum_d  = 1'b0;
        acc_d        = acc_q ^ r_data;
`else
        dout_last_d  = (r_addr_q == last_q);
`endif
        state_d      = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          dout_valid_d = 1'b0;
          if (r_addr_q == last_q) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            r_addr_d = r_addr_q + ADDR_W'(1);
            state_d  = S_FETCH;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        // First cycle loads the checksum beat, then wait for its handshake
        if (!dout_valid_q) begin
          dout_data_d  = acc_q;
          dout_idx_d   = '0;
          dout_last_d  = 1'b1;
          dout_csum_d  = 1'b1;
          dout_valid_d = 1'b1;
        end else if (dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = S_DONE;
          done_d       = 1'b1;
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      r_addr_q     <= '0;
      last_q       <= '0;
      dout_data_q  <= '0;
      dout_idx_q   <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_addr_q     <= r_addr_d;
      last_q       <= last_d;
      dout_data_q  <= dout_data_d;
      dout_idx_q   <= dout_idx_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      dout_csum_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      dout_csum_q <= dout_csum_d;
    end
  end
  assign dout_csum = dout_csum_q;
`else
  assign dout_csum = 1'b0;
`endif

  assign r_addr     = r_addr_q;
  assign dout_data  = dout_data_q;
  assign dout_idx   = dout_idx_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a register-file model feeds r_data, a monitor checks every presented beat.
module tb_regfile_dump;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        last;
    logic        csum;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  r_addr;
  logic [63:0] r_data;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [63:0] dout_data;
  logic [4:0]  dout_idx;
  logic        dout_last;
  logic        dout_csum;
  logic        busy;
  logic        done;

  logic [63:0] regs [32];
  beat_t       expq [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          start_cyc = 0;
  int          hs31_cyc = 0;

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .r_addr(r_addr), .r_data(r_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_idx(dout_idx), .dout_last(dout_last), .dout_csum(dout_csum),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Register-file read port: XZR reads as zero
  assign r_data = (r_addr == 5'd31) ? 64'd0 : regs[r_addr];

  // Monitor: every cycle a beat is presented it must match the queue head; pop on handshake
  always @(negedge clk) begin
    beat_t e, a;
    if (done) done_cnt++;
    if (reset && dout_valid) begin
      a = '{data: dout_data, idx: dout_idx, last: dout_last, csum: dout_csum};
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got idx=%0d data=%h last=%0b csum=%0b, queue empty",
                 a.idx, a.data, a.last, a.csum);
      end else begin
        e = expq[0];
        if (a !== e) begin
          bad++;
          $display("FAIL beat got idx=%0d data=%h last=%0b csum=%0b want idx=%0d data=%h last=%0b csum=%0b",
                   a.idx, a.data, a.last, a.csum, e.idx, e.data, e.last, e.csum);
        end
        if (dout_ready) begin
          void'(expq.pop_front());
          if (a.idx == 5'd31 && !a.csum) hs31_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_range(input int f, input int l);
    beat_t b;
    logic [63:0] acc;
    acc = '0;
    for (int a = f; a <= l; a++) begin
      b.data = (a == 31) ? 64'd0 : regs[a];
      b.idx  = 5'(a);
`ifdef REGDUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (a == l);
`endif
      b.csum = 1'b0;
      acc    = acc ^ b.data;
      expq.push_back(b);
    end
`ifdef REGDUMP_CHECKSUM_EN
    b = '{data: acc, idx: 5'd0, last: 1'b1, csum: 1'b1};
    expq.push_back(b);
`endif
  endtask

  task automatic start_dump(input int f, input int l);
    @(posedge clk); #1;
    start = 1'b1; first_addr = 5'(f); last_addr = 5'(l);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int base, input int budget, input bit toggle);
    int n;
    n = 0;
    while (done_cnt <= base && n < budget) begin
      @(posedge clk); #1;
      if (toggle) dout_ready = ~dout_ready;
      n++;
    end
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_count"}, 64'(done_cnt - base), 64'd1);
    check({name, "_queue_empty"}, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int base;
    bit found;
    for (int i = 0; i < 32; i++) regs[i] = 64'(i);

    // Reset state
    #12;
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_raddr", 64'(r_addr), 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk); reset = 1'b1;

    // Full 0..31 walk with ready held high
    base = done_cnt;
    push_range(0, 31);
    start_dump(0, 31);
    check("full_busy", 64'(busy), 64'd1);
    run_until_done("full", base, 200, 1'b0);
    check("full_latency", 64'(hs31_cyc - start_cyc), 64'd64);
    check("full_busy_after", 64'(busy), 64'd0);

    // 5..7 with ready toggling every cycle
    base = done_cnt;
    push_range(5, 7);
    start_dump(5, 7);
    run_until_done("toggle", base, 100, 1'b1);

    // Empty range 9..3
    base = done_cnt;
    push_range(9, 3);
    start_dump(9, 3);
`ifndef REGDUMP_CHECKSUM_EN
    check("empty_done_pulse", {62'd0, busy, done}, 64'd3);
    check("empty_no_valid", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;
    check("empty_after", {62'd0, busy, done}, 64'd0);
`endif
    run_until_done("empty", base, 50, 1'b0);

    // Start pulsed again while busy must be ignored
    base = done_cnt;
    push_range(0, 3);
    start_dump(0, 3);
    @(posedge clk); #1;
    start = 1'b1; first_addr = 5'd10; last_addr = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    run_until_done("restart", base, 100, 1'b0);

    // Asynchronous reset in the middle of a dump
    base = done_cnt;
    push_range(0, 31);
    start_dump(0, 31);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (dout_valid && dout_idx == 5'd12) found = 1'b1;
    end
    check("abort_reached_idx12", 64'(found), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_valid", {61'd0, dout_valid, dout_last, dout_csum}, 64'd0);
    check("abort_data", dout_data, 64'd0);
    check("abort_idx_raddr", {54'd0, dout_idx, r_addr}, 64'd0);
    check("abort_busy_done", {62'd0, busy, done}, 64'd0);
    expq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    base = done_cnt;
    push_range(0, 1);
    start_dump(0, 1);
    run_until_done("post_abort", base, 50, 1'b0);

`ifdef REGDUMP_CHECKSUM_EN
    // Checksum of 0xA5 ^ 0x0F
    regs[1] = 64'hA5;
    regs[2] = 64'h0F;
    base = done_cnt;
    expq.push_back('{data: 64'hA5, idx: 5'd1, last: 1'b0, csum: 1'b0});
    expq.push_back('{data: 64'h0F, idx: 5'd2, last: 1'b0, csum: 1'b0});
    expq.push_back('{data: 64'hAA, idx: 5'd0, last: 1'b1, csum: 1'b1});
    start_dump(1, 2);
    run_until_done("csum", base, 50, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
